// File: rtl/pcx_req_arb.sv
// pcx_req_arb: round-robin arbiter for the PCX request path into the ccx2mb request FIFO
//   gclk      in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   req_vld   in   [NUM_REQ]        per-port packet valid, held until accepted
//   req_atom  in   [NUM_REQ]        packet is the first half of an atomic pair
//   req_data  in   [NUM_REQ*PCX_W]  per-port packet, port i at [i*PCX_W +: PCX_W]
//   req_rdy   out  [NUM_REQ]        one-hot combinational accept
//   pcx_wr    out                   registered FIFO write strobe
//   pcx_data  out  [PCX_W]          registered FIFO write data
//   pcx_full  in                    FIFO almost-full (one free entry of slack)
//   arb_busy  out                   registered, high while an atomic pair is in progress
//   stall_cnt out  [16]             only with PCX_ARB_STALL_CNT_EN: saturating count of cycles with a request blocked by pcx_full
module pcx_req_arb #(
    parameter int NUM_REQ = 2,
    parameter int PCX_W   = 124
) (
    input  logic                     gclk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ-1:0]       req_atom,
    input  logic [NUM_REQ*PCX_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic                     pcx_wr,
    output logic [PCX_W-1:0]         pcx_data,
    input  logic                     pcx_full,
    output logic                     arb_busy
`ifdef PCX_ARB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ARB, LOCK} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, owner, win, idx;
    logic [NUM_REQ-1:0] elig;
    logic              found, accept;

    // Search starts one past the last winner; in LOCK only the owner may win.
    always_comb begin
        elig  = (state == LOCK) ? (req_vld & (NUM_REQ'(1) << owner)) : req_vld;
        win   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        accept    = found && !pcx_full && !reset;
        req_rdy   = accept ? (NUM_REQ'(1) << win) : '0;
        state_nxt = !accept ? state : (state == LOCK) ? ARB : req_atom[win] ? LOCK : ARB;
    end

    // pcx_data only loads on accept, so X on unselected ports never reaches it.
    always_ff @(posedge gclk) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= IW'(NUM_REQ - 1);
            owner    <= '0;
            pcx_wr   <= 1'b0;
            pcx_data <= '0;
            arb_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            arb_busy <= (state_nxt == LOCK);
            pcx_wr   <= accept;
            if (accept) begin
                pcx_data <= req_data[win*PCX_W +: PCX_W];
                rr_ptr   <= win;
            end
            if (accept && state == ARB && req_atom[win])
                owner <= win;
        end
    end

`ifdef PCX_ARB_STALL_CNT_EN
    always_ff @(posedge gclk) begin
        if (reset)
            stall_cnt <= '0;
        else if (|req_vld && pcx_full && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pcx_req_arb.sv
// tb_pcx_req_arb: directed and random checks of pcx_req_arb against a behavioural model
module tb_pcx_req_arb;
    localparam int N = 4;
    localparam int W = 124;

    logic             gclk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_vld, req_atom, req_rdy;
    logic [N*W-1:0]   req_data;
    logic             pcx_wr, pcx_full, arb_busy;
    logic [W-1:0]     pcx_data;
`ifdef PCX_ARB_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    pcx_req_arb #(.NUM_REQ(N), .PCX_W(W)) dut (
        .gclk(gclk), .reset(reset), .req_vld(req_vld), .req_atom(req_atom),
        .req_data(req_data), .req_rdy(req_rdy), .pcx_wr(pcx_wr), .pcx_data(pcx_data),
        .pcx_full(pcx_full), .arb_busy(arb_busy)
`ifdef PCX_ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 gclk = ~gclk;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: last granted port, lock owner, expected registered outputs
    int           m_last, m_owner;
    bit           m_lock, m_rst_seen;
    logic         e_wr, e_busy;
    logic [W-1:0] e_data;
    int           e_stall;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_pkt();
        return W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // One clock: inputs already driven after a falling edge.
    task automatic cyc();
        int sel, best, d;
        logic [N-1:0] er;
        #1;
        sel  = -1;
        best = N;
        if (!reset && !pcx_full) begin
            if (m_lock) begin
                if (req_vld[m_owner]) sel = m_owner;
            end else begin
                // winner = valid port at the smallest cyclic distance past the last winner
                for (int i = 0; i < N; i++) begin
                    d = (i - m_last - 1 + 2 * N) % N;
                    if (req_vld[i] && d < best) begin
                        best = d;
                        sel  = i;
                    end
                end
            end
        end
        er = '0;
        if (sel >= 0) er[sel] = 1'b1;
        chk("req_rdy", req_rdy, er);
        @(posedge gclk);
        if (reset) begin
            m_last = N - 1; m_lock = 0; m_owner = 0;
            e_wr = 0; e_busy = 0; e_data = '0; e_stall = 0; m_rst_seen = 1;
        end else begin
            m_rst_seen = 0;
            e_wr = (sel >= 0);
            if (sel >= 0) begin
                e_data = req_data[sel*W +: W];
                m_last = sel;
                if (m_lock) m_lock = 0;
                else if (req_atom[sel]) begin
                    m_lock  = 1;
                    m_owner = sel;
                end
            end
            e_busy = m_lock;
            if (|req_vld && pcx_full && e_stall < 65535) e_stall++;
        end
        #1;
        chk("pcx_wr", pcx_wr, e_wr);
        chk("arb_busy", arb_busy, e_busy);
        if (e_wr || m_rst_seen) chk("pcx_data", pcx_data, e_data);
`ifdef PCX_ARB_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e_stall);
`endif
        @(negedge gclk);
    endtask

    task automatic set_pkt(input int p, input logic [W-1:0] v);
        req_data[p*W +: W] = v;
    endtask

    task automatic do_reset();
        reset = 1; req_vld = '0; req_atom = '0; pcx_full = 0;
        cyc();
        reset = 0;
    endtask

    initial begin
        reset = 1; req_vld = '0; req_atom = '0; pcx_full = 0; req_data = '0;
        m_last = N - 1; m_owner = 0; m_lock = 0; m_rst_seen = 1;
        e_wr = 0; e_busy = 0; e_data = '0; e_stall = 0;
        @(negedge gclk);
        cyc();
        cyc();
        chk("rst_pcx_wr", pcx_wr, 1'b0);
        chk("rst_arb_busy", arb_busy, 1'b0);
        reset = 0;

        // steady two-port round robin
        req_vld = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            set_pkt(0, rnd_pkt()); set_pkt(1, rnd_pkt());
            cyc();
        end

        // atomic pair on port 1, port 0 joins at the first-half accept
        do_reset();
        req_vld = 4'b0010; req_atom = 4'b0010; set_pkt(1, 124'hA1);
        cyc();
        chk("atom_busy", arb_busy, 1'b1);
        req_vld = 4'b0011; req_atom = 4'b0000; set_pkt(1, 124'hA2); set_pkt(0, 124'hB0);
        cyc();
        chk("atom_second", pcx_data, 124'hA2);
        req_vld = 4'b0001;
        cyc();
        chk("after_atom", pcx_data, 124'hB0);
        req_vld = '0;
        cyc();

        // full back-pressure with one write in flight
        do_reset();
        req_vld = 4'b0011;
        cyc();
        pcx_full = 1;
        for (int i = 0; i < 5; i++) cyc();
        chk("full_no_wr", pcx_wr, 1'b0);
`ifdef PCX_ARB_STALL_CNT_EN
        chk("stall_five", stall_cnt, 16'd5);
`endif
        pcx_full = 0;
        cyc();

        // atomic first half blocked by full stays in ARB
        req_vld = 4'b0100; req_atom = 4'b0100; pcx_full = 1;
        cyc();
        pcx_full = 0; req_vld = 4'b0000; req_atom = 4'b0000;
        cyc();

        // reset while locked on port 1
        do_reset();
        req_vld = 4'b0010; req_atom = 4'b0010;
        cyc();
        reset = 1; req_vld = 4'b0011; req_atom = 4'b0000;
        cyc();
        chk("rst_lock_busy", arb_busy, 1'b0);
        reset = 0;
        cyc();
        cyc();

        // lone port 3
        do_reset();
        req_vld = 4'b1000; set_pkt(3, 124'hABC);
        #1;
        chk("p3_rdy", req_rdy, 4'b1000);
        cyc();
        chk("p3_data", pcx_data, 124'hABC);
        req_vld = '0;
        cyc();

        // owner drops valid during LOCK
        req_vld = 4'b0001; req_atom = 4'b0001; set_pkt(0, rnd_pkt());
        cyc();
        req_vld = 4'b1110; req_atom = 4'b0000;
        for (int i = 0; i < 3; i++) cyc();
        req_vld = 4'b1111; set_pkt(0, 124'h5EC0);
        cyc();
        chk("owner_second", pcx_data, 124'h5EC0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            pcx_full = ($urandom_range(0, 99) < 20);
            req_vld  = N'($urandom);
            req_atom = N'($urandom) & N'($urandom);
            for (int p = 0; p < N; p++) set_pkt(p, rnd_pkt());
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
